hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, in the EX stage beside the main ALU.
- Consumes the 5-bit ALUCtrl code from the ALU controller, plus rs/rt operands from the ID/EX register.
- Handles mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Raises a stall request so hazard logic holds the front of the pipeline while an iterative operation is in flight.

Parameters:
- CTRL_MULT, 5'h10, ALUCtrl code for signed multiply
- CTRL_MULTU, 5'h11, ALUCtrl code for unsigned multiply
- CTRL_DIV, 5'h12, ALUCtrl code for signed divide
- CTRL_DIVU, 5'h13, ALUCtrl code for unsigned divide
- CTRL_MFHI, 5'h14, ALUCtrl code for move from HI
- CTRL_MTHI, 5'h15, ALUCtrl code for move to HI
- CTRL_MFLO, 5'h16, ALUCtrl code for move from LO
- CTRL_MTLO, 5'h17, ALUCtrl code for move to LO

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  EX-stage instruction valid
- ALUCtrl  in  5  operation code from the ALU controller
- rs_data  in  32  operand A: multiplicand/dividend, or mthi/mtlo source
- rt_data  in  32  operand B: multiplier/divisor
- flush  in  1  squash the in-flight operation (branch/exception)
- result_out  out  32  HI for mfhi, LO for mflo, else 0 (combinational)
- hi_out  out  32  HI register
- lo_out  out  32  LO register
- busy  out  1  iterative operation in progress
- stall_req  out  1  hold the IF/ID/EX stages this cycle
- done  out  1  one-cycle pulse when HI/LO are written by mul/div
- div_zero  out  1  one-cycle pulse with done when the divisor was 0

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; HI, LO and all datapath registers 0.
  - busy, stall_req, done, div_zero all 0.
- A "md op" is start=1 with ALUCtrl equal to any of the eight codes. Any other code is ignored entirely.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - Accept a md op at the clock edge.
  - MTHI/MTLO: HI (or LO) <= rs_data at that edge; stays IDLE; busy stays 0.
  - MFHI/MFLO: result_out driven combinationally in the same cycle; no state change.
  - MULT/MULTU/DIV/DIVU:
    - Latch the operands; signed ops latch absolute values plus result-sign bits.
    - Clear the 6-bit counter; go to RUN.
  - DIV/DIVU with rt_data==0: go directly to FIX, skipping RUN.
- RUN:
  - Exactly 32 cycles, one bit per cycle; counter 0..31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 64-bit remainder/quotient pair.
  - Go to FIX after count 31.
- FIX (1 cycle):
  - Apply sign correction, write HI/LO, pulse done, return to IDLE.
  - Signed multiply: 64-bit two's-complement product; HI = [63:32], LO = [31:0].
  - Signed divide: quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - Divide by zero: HI <= rs_data, LO <= 0xFFFFFFFF, div_zero pulses with done.
- Latency:
  - mul/div: accept edge + 33 edges; HI/LO valid after the 34th edge counted from accept.
  - div-by-zero: 2 edges (accept, FIX).
- busy: 1 in RUN and FIX.
- stall_req:
  - = busy OR (state==IDLE AND start AND ALUCtrl in {MULT,MULTU,DIV,DIVU}).
  - Upstream holds the instruction behind the op; any md op presented while busy is not executed until IDLE.
  - This includes MFHI/MFLO, which must never read stale HI/LO.
- flush:
  - In RUN or FIX: return to IDLE next edge; HI/LO unchanged; no done pulse.
  - In IDLE: suppress acceptance of that cycle's md op.
  - flush has priority over start.
- Simultaneous FIX and a new start: the new op is not accepted until IDLE; stall_req holds it.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD -> busy for 33 cycles, done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=0x1234, rt=0 -> done and div_zero pulse 2 edges after accept; HI=0x1234, LO=0xFFFFFFFF.
- MTHI 0xA5A5A5A5, then MFHI in the next cycle -> result_out=0xA5A5A5A5.
- MFLO held during MULT -> stall_req=1 until IDLE, then the new LO is returned.
- flush at RUN count 10 -> IDLE next edge, HI/LO unchanged, no done.
- rst_n low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Purpose  : Iterative 32x32 multiply / divide unit with HI/LO registers.
// Revision : 1.0
// ============================================================================
module hilo_muldiv_unit #(
  parameter logic [4:0] CTRL_MULT  = 5'h10,
  parameter logic [4:0] CTRL_MULTU = 5'h11,
  parameter logic [4:0] CTRL_DIV   = 5'h12,
  parameter logic [4:0] CTRL_DIVU  = 5'h13,
  parameter logic [4:0] CTRL_MFHI  = 5'h14,
  parameter logic [4:0] CTRL_MTHI  = 5'h15,
  parameter logic [4:0] CTRL_MFLO  = 5'h16,
  parameter logic [4:0] CTRL_MTLO  = 5'h17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  ALUCtrl,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic [31:0] result_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_a, r_b;
  logic [63:0] r_acc;
  logic        r_is_div, r_neg_q, r_neg_r, r_dz, r_done, r_div_zero;

  logic        w_is_mul, w_is_div, w_signed, w_iter, w_accept, w_rs_neg, w_rt_neg, w_dz;
  logic [31:0] w_rs_abs, w_rt_abs;
  logic [32:0] w_mul_sum, w_rem_sh;
  logic [63:0] w_mul_acc, w_div_acc, w_prod;
  logic [31:0] w_div_sub, w_quo, w_rem;

  assign w_is_mul = (ALUCtrl == CTRL_MULT) || (ALUCtrl == CTRL_MULTU);
  assign w_is_div = (ALUCtrl == CTRL_DIV)  || (ALUCtrl == CTRL_DIVU);
  assign w_signed = (ALUCtrl == CTRL_MULT) || (ALUCtrl == CTRL_DIV);
  assign w_iter   = w_is_mul || w_is_div;
  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_dz     = w_is_div && (rt_data == 32'd0);

  assign w_rs_neg = w_signed && rs_data[31];
  assign w_rt_neg = w_signed && rt_data[31];
  assign w_rs_abs = w_rs_neg ? (32'd0 - rs_data) : rs_data;
  assign w_rt_abs = w_rt_neg ? (32'd0 - rt_data) : rt_data;

  // Multiply: accumulator holds {partial product, remaining multiplier bits}.
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
  assign w_mul_acc = {w_mul_sum, r_acc[31:1]};

  // Divide: accumulator holds {remainder, dividend/quotient}; shifted remainder needs 33 bits.
  assign w_rem_sh  = r_acc[63:31];
  assign w_div_sub = w_rem_sh[31:0] - r_b;
  assign w_div_acc = (w_rem_sh >= {1'b0, r_b}) ? {w_div_sub, r_acc[30:0], 1'b1}
                                               : {r_acc[62:0], 1'b0};

  assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
  assign w_quo  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_iter) w_next = w_dz ? S_FIX : S_RUN;
      S_RUN:  if (flush) w_next = S_IDLE;
              else if (r_cnt == 6'd31) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 6'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_acc      <= 64'd0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (ALUCtrl == CTRL_MTHI) r_hi <= rs_data;
          if (ALUCtrl == CTRL_MTLO) r_lo <= rs_data;
          if (w_iter) begin
            r_cnt    <= 6'd0;
            r_is_div <= w_is_div;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_is_div && w_rs_neg;
            r_dz     <= w_dz;
            // Divide-by-zero keeps the raw dividend for HI.
            r_a      <= w_dz ? rs_data : w_rs_abs;
            r_b      <= w_rt_abs;
            r_acc    <= w_is_div ? {32'd0, w_rs_abs} : {32'd0, w_rt_abs};
          end
        end
        S_RUN: if (!flush) begin
          r_acc <= r_is_div ? w_div_acc : w_mul_acc;
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: if (!flush) begin
          r_done     <= 1'b1;
          r_div_zero <= r_dz;
          if (r_dz) begin
            r_hi <= r_a;
            r_lo <= 32'hFFFF_FFFF;
          end else if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign stall_req  = busy || ((r_state == S_IDLE) && start && w_iter);
  assign done       = r_done;
  assign div_zero   = r_div_zero;
  assign hi_out     = r_hi;
  assign lo_out     = r_lo;
  assign result_out = (ALUCtrl == CTRL_MFHI) ? r_hi :
                      (ALUCtrl == CTRL_MFLO) ? r_lo : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_unit
// Purpose  : Directed/random checks of hilo_muldiv_unit against a scoreboard.
// Revision : 1.0
// ============================================================================
module tb_hilo_muldiv_unit;
  localparam logic [4:0] C_MULT  = 5'h10;
  localparam logic [4:0] C_MULTU = 5'h11;
  localparam logic [4:0] C_DIV   = 5'h12;
  localparam logic [4:0] C_DIVU  = 5'h13;
  localparam logic [4:0] C_MFHI  = 5'h14;
  localparam logic [4:0] C_MTHI  = 5'h15;
  localparam logic [4:0] C_MFLO  = 5'h16;
  localparam logic [4:0] C_MTLO  = 5'h17;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [4:0]  alu_ctrl;
  logic [31:0] rs, rt;
  logic [31:0] result_out, hi_out, lo_out;
  logic        busy, stall_req, done, div_zero;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  always #5 clk = ~clk;

  hilo_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUCtrl(alu_ctrl),
    .rs_data(rs), .rt_data(rt), .flush(flush),
    .result_out(result_out), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .stall_req(stall_req), .done(done), .div_zero(div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sbv, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    e.dz = 1'b0; e.lat = 34; e.hi = 32'd0; e.lo = 32'd0;
    case (op)
      C_MULT:  begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
      C_MULTU: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.dz = 1'b1; e.lat = 2; e.hi = a; e.lo = 32'hFFFF_FFFF;
        end else if (op == C_DIV) begin
          sq = sa / sbv; sr = sa % sbv; e.lo = sq[31:0]; e.hi = sr[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  task automatic do_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit hold_mflo);
    exp_t e;
    int edges, busy_cyc;
    @(negedge clk);
    start = 1'b1; alu_ctrl = op; rs = a; rt = b;
    sb.push_back(model(op, a, b));
    #1 check({tag, "/stall_pre"}, {31'd0, stall_req}, 32'd1);
    @(posedge clk);
    edges = 1; busy_cyc = 0;
    @(negedge clk);
    if (hold_mflo) alu_ctrl = C_MFLO; else start = 1'b0;
    #1;
    while (!done && edges < 60) begin
      if (busy) busy_cyc++;
      if (hold_mflo) check({tag, "/stall_hold"}, {31'd0, stall_req}, 32'd1);
      @(posedge clk);
      edges++;
      @(negedge clk);
      #1;
    end
    e = sb.pop_front();
    check({tag, "/latency"}, 32'(edges), 32'(e.lat));
    check({tag, "/busy_cycles"}, 32'(busy_cyc), 32'(e.lat - 1));
    check({tag, "/done"}, {31'd0, done}, 32'd1);
    check({tag, "/busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "/hi"}, hi_out, e.hi);
    check({tag, "/lo"}, lo_out, e.lo);
    check({tag, "/div_zero"}, {31'd0, div_zero}, {31'd0, e.dz});
    if (hold_mflo) begin
      check({tag, "/mflo_result"}, result_out, e.lo);
      check({tag, "/stall_release"}, {31'd0, stall_req}, 32'd0);
    end
    last_hi = e.hi; last_lo = e.lo;
    start = 1'b0;
    @(negedge clk);
    #1 check({tag, "/done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [4:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; alu_ctrl = 5'd0; rs = 32'd0; rt = 32'd0;
    #12;
    check("reset/hi", hi_out, 32'd0);
    check("reset/lo", lo_out, 32'd0);
    check("reset/busy", {31'd0, busy}, 32'd0);
    check("reset/stall", {31'd0, stall_req}, 32'd0);
    check("reset/done", {31'd0, done}, 32'd0);
    check("reset/div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_md("mult_7x-3", C_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
    do_md("multu_max", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_md("div_-7/2", C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_md("div_min/-1", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_md("divu_by0", C_DIVU, 32'h0000_1234, 32'd0, 1'b0);
    do_md("div_by0", C_DIV, 32'hFFFF_0000, 32'd0, 1'b0);
    do_md("divu_100/7", C_DIVU, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 6; i++) begin
      op = C_MULT + 5'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      do_md("random", op, a, b, 1'b0);
    end

    // MTHI then MFHI in the following cycle
    @(negedge clk);
    start = 1'b1; alu_ctrl = C_MTHI; rs = 32'hA5A5_A5A5;
    #1 check("mthi/stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    alu_ctrl = C_MFHI; rs = 32'd0;
    #1;
    check("mfhi/result", result_out, 32'hA5A5_A5A5);
    check("mthi/busy", {31'd0, busy}, 32'd0);
    last_hi = 32'hA5A5_A5A5;
    @(negedge clk);
    alu_ctrl = C_MTLO; rs = 32'h5A5A_1234;
    @(negedge clk);
    alu_ctrl = C_MFLO;
    #1 check("mflo/result", result_out, 32'h5A5A_1234);
    check("mtlo/hi_kept", hi_out, last_hi);
    last_lo = 32'h5A5A_1234;
    start = 1'b0;

    do_md("mult_hold_mflo", C_MULT, 32'hFFFF_FF00, 32'd300, 1'b1);

    // flush at RUN count 10
    @(negedge clk);
    start = 1'b1; alu_ctrl = C_MULTU; rs = 32'd12345; rt = 32'd678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_run/busy", {31'd0, busy}, 32'd0);
    check("flush_run/hi", hi_out, last_hi);
    check("flush_run/lo", lo_out, last_lo);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("flush_run/no_done", 32'(ndone), 32'd0);

    // flush in IDLE suppresses the op
    @(negedge clk);
    start = 1'b1; alu_ctrl = C_MTHI; rs = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 check("flush_idle/hi", hi_out, last_hi);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; alu_ctrl = C_MULTU; rs = 32'h0000_FFFF; rt = 32'h0000_FFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; alu_ctrl = C_MFHI;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 check("midrun/busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst/hi", hi_out, 32'd0);
    check("midrun_rst/lo", lo_out, 32'd0);
    check("midrun_rst/busy", {31'd0, busy}, 32'd0);
    check("midrun_rst/stall", {31'd0, stall_req}, 32'd0);
    check("midrun_rst/done", {31'd0, done}, 32'd0);
    check("midrun_rst/result", result_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
